// File: rtl/coms_master.sv
// ---------------------------------------------------------------------------
// coms_master
//
// RS485 bus master for motor-controller slaves. It sends a 7-byte status
// request or a 10-byte setpoint frame through an external uart_tx, and for a
// status request it hunts for the 4-byte status magic in the uart_rx stream.
// It then captures the 21-byte remainder of the status frame and, if the
// CRC-16 and the slave ID check out, publishes the decoded fields.
//
// Ports
//   CLK, reset_n            clock; synchronous active-low reset
//   cmd_poll, cmd_setpoint  command pulses, accepted only while idle
//   target_id, setpoint_cmd slave ID and setpoint, latched on acceptance
//   busy                    high whenever a transaction is in progress
//   tx_byte/tx_start        byte and start pulse to uart_tx
//   tx_done                 byte-finished pulse from uart_tx
//   driver_enable           RS485 driver enable, high while transmitting
//   rx_byte/rx_valid        received byte and strobe from uart_rx
//   status_id .. current    fields of the last good status frame
//   status_valid            pulse: good status frame captured
//   setpoint_sent           pulse: setpoint frame fully transmitted
//   crc_error               pulse: status frame failed CRC
//   timeout                 pulse: no good status frame in TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module coms_master #(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               cmd_poll,
    input  logic               cmd_setpoint,
    input  logic [7:0]         target_id,
    input  logic signed [23:0] setpoint_cmd,
    output logic               busy,
    output logic [7:0]         tx_byte,
    output logic               tx_start,
    input  logic               tx_done,
    output logic               driver_enable,
    input  logic [7:0]         rx_byte,
    input  logic               rx_valid,
    output logic [7:0]         status_id,
    output logic [7:0]         control_mode,
    output logic signed [23:0] encoder0_position,
    output logic signed [23:0] encoder1_position,
    output logic signed [23:0] setpoint_rx,
    output logic signed [23:0] duty,
    output logic signed [23:0] displacement,
    output logic signed [12:0] current,
    output logic               status_valid,
    output logic               setpoint_sent,
    output logic               crc_error,
    output logic               timeout
);

    // Counter holds 0 .. TIMEOUT_CYCLES-1.
    localparam int unsigned    CntW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    localparam logic [4:0]  ReqLast    = 5'd6;   // index of last request byte
    localparam logic [4:0]  SpLast     = 5'd9;   // index of last setpoint byte
    localparam logic [4:0]  RxCrcFirst = 5'd19;  // first CRC byte of the captured 21
    localparam logic [4:0]  RxLast     = 5'd20;
    localparam logic [31:0] StatusMagic = 32'h1CEB_00DA;

    typedef enum logic [2:0] {
        StIdle,
        StSendReq,
        StSendSp,
        StWaitMagic,
        StRecvStatus,
        StCheckCrc
    } state_t;

    state_t           state_q;
    logic [7:0]       id_q;
    logic [23:0]      sp_q;
    logic [15:0]      tx_crc_q;
    logic [4:0]       idx_q;
    logic [31:0]      magic_q;
    logic [167:0]     buf_q;      // frame bytes 4..24, first received at the top
    logic [15:0]      rx_crc_q;
    logic [CntW-1:0]  cnt_q;

    // CRC-16, poly 0x8005, MSB first, one byte per call.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc_in,
                                                 input logic [7:0]  data);
        logic [15:0] crc;
        crc = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (crc[15] ^ data[i]) crc = {crc[14:0], 1'b0} ^ 16'h8005;
            else                   crc = {crc[14:0], 1'b0};
        end
        return crc;
    endfunction

    function automatic logic [7:0] req_byte(input logic [4:0]  i,
                                            input logic [7:0]  id,
                                            input logic [15:0] crc);
        logic [7:0] b;
        case (i)
            5'd0:    b = 8'h1C;
            5'd1:    b = 8'hE1;
            5'd2:    b = 8'hCE;
            5'd3:    b = 8'hBB;
            5'd4:    b = id;
            5'd5:    b = crc[15:8];
            default: b = crc[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [7:0] sp_byte(input logic [4:0]  i,
                                           input logic [7:0]  id,
                                           input logic [23:0] sp,
                                           input logic [15:0] crc);
        logic [7:0] b;
        case (i)
            5'd4:    b = id;
            5'd5:    b = sp[23:16];
            5'd6:    b = sp[15:8];
            5'd7:    b = sp[7:0];
            5'd8:    b = crc[15:8];
            5'd9:    b = crc[7:0];
            default: b = 8'hD0;
        endcase
        return b;
    endfunction

    // Frame CRCs are computed from the raw inputs so they can be latched
    // together with the command.
    logic [15:0] req_crc;
    logic [15:0] sp_crc;
    logic [4:0]  idx_nxt;
    logic [31:0] magic_shift;
    logic [15:0] rx_crc_nxt;
    logic        timeout_hit;

    always_comb begin
        req_crc     = crc16_update(16'hFFFF, target_id);
        sp_crc      = crc16_update(16'hFFFF, target_id);
        sp_crc      = crc16_update(sp_crc, setpoint_cmd[23:16]);
        sp_crc      = crc16_update(sp_crc, setpoint_cmd[15:8]);
        sp_crc      = crc16_update(sp_crc, setpoint_cmd[7:0]);
        idx_nxt     = idx_q + 5'd1;
        magic_shift = {magic_q[23:0], rx_byte};
        rx_crc_nxt  = crc16_update(rx_crc_q, rx_byte);
        timeout_hit = (cnt_q == CntLast);
    end

    // Captured frame fields.
    logic [7:0]  fr_id;
    logic [7:0]  fr_mode;
    logic [23:0] fr_enc0;
    logic [23:0] fr_enc1;
    logic [23:0] fr_sp;
    logic [23:0] fr_duty;
    logic [23:0] fr_disp;
    logic [12:0] fr_cur;
    logic [15:0] fr_crc;
    logic        unused_hdr;

    assign fr_id   = buf_q[167:160];
    assign fr_mode = buf_q[159:152];
    assign fr_enc0 = buf_q[151:128];
    assign fr_enc1 = buf_q[127:104];
    assign fr_sp   = buf_q[103:80];
    assign fr_duty = buf_q[79:56];
    assign fr_disp = buf_q[55:32];
    assign fr_cur  = buf_q[28:16];
    assign fr_crc  = buf_q[15:0];
    // Upper three bits of the current high byte carry no information.
    assign unused_hdr = ^buf_q[31:29];

    assign busy = (state_q != StIdle);

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q           <= StIdle;
            id_q              <= '0;
            sp_q              <= '0;
            tx_crc_q          <= '0;
            idx_q             <= '0;
            magic_q           <= '0;
            buf_q             <= '0;
            rx_crc_q          <= '0;
            cnt_q             <= '0;
            tx_byte           <= '0;
            tx_start          <= 1'b0;
            driver_enable     <= 1'b0;
            status_id         <= '0;
            control_mode      <= '0;
            encoder0_position <= '0;
            encoder1_position <= '0;
            setpoint_rx       <= '0;
            duty              <= '0;
            displacement      <= '0;
            current           <= '0;
            status_valid      <= 1'b0;
            setpoint_sent     <= 1'b0;
            crc_error         <= 1'b0;
            timeout           <= 1'b0;
        end else begin
            tx_start      <= 1'b0;
            status_valid  <= 1'b0;
            setpoint_sent <= 1'b0;
            crc_error     <= 1'b0;
            timeout       <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    // Setpoint has priority over a simultaneous poll.
                    if (cmd_setpoint) begin
                        state_q       <= StSendSp;
                        id_q          <= target_id;
                        sp_q          <= setpoint_cmd;
                        tx_crc_q      <= sp_crc;
                        idx_q         <= '0;
                        tx_byte       <= 8'hD0;
                        tx_start      <= 1'b1;
                        driver_enable <= 1'b1;
                    end else if (cmd_poll) begin
                        state_q       <= StSendReq;
                        id_q          <= target_id;
                        tx_crc_q      <= req_crc;
                        idx_q         <= '0;
                        tx_byte       <= 8'h1C;
                        tx_start      <= 1'b1;
                        driver_enable <= 1'b1;
                    end
                end

                StSendReq: begin
                    if (tx_done) begin
                        if (idx_q == ReqLast) begin
                            state_q       <= StWaitMagic;
                            driver_enable <= 1'b0;
                            magic_q       <= '0;
                            cnt_q         <= '0;
                        end else begin
                            idx_q    <= idx_nxt;
                            tx_byte  <= req_byte(idx_nxt, id_q, tx_crc_q);
                            tx_start <= 1'b1;
                        end
                    end
                end

                StSendSp: begin
                    if (tx_done) begin
                        if (idx_q == SpLast) begin
                            state_q       <= StIdle;
                            driver_enable <= 1'b0;
                            setpoint_sent <= 1'b1;
                        end else begin
                            idx_q    <= idx_nxt;
                            tx_byte  <= sp_byte(idx_nxt, id_q, sp_q, tx_crc_q);
                            tx_start <= 1'b1;
                        end
                    end
                end

                StWaitMagic: begin
                    if (timeout_hit) begin
                        state_q <= StIdle;
                        timeout <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (rx_valid) begin
                            magic_q <= magic_shift;
                            if (magic_shift == StatusMagic) begin
                                state_q  <= StRecvStatus;
                                idx_q    <= '0;
                                rx_crc_q <= 16'hFFFF;
                            end
                        end
                    end
                end

                StRecvStatus: begin
                    if (timeout_hit) begin
                        state_q <= StIdle;
                        timeout <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (rx_valid) begin
                            buf_q <= {buf_q[159:0], rx_byte};
                            // The trailing two bytes are the CRC itself.
                            if (idx_q < RxCrcFirst) rx_crc_q <= rx_crc_nxt;
                            if (idx_q == RxLast) state_q <= StCheckCrc;
                            else                 idx_q   <= idx_nxt;
                        end
                    end
                end

                StCheckCrc: begin
                    if (timeout_hit) begin
                        state_q <= StIdle;
                        timeout <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (rx_crc_q != fr_crc) begin
                            state_q   <= StIdle;
                            crc_error <= 1'b1;
                        end else if (fr_id == id_q) begin
                            state_q           <= StIdle;
                            status_valid      <= 1'b1;
                            status_id         <= fr_id;
                            control_mode      <= fr_mode;
                            encoder0_position <= fr_enc0;
                            encoder1_position <= fr_enc1;
                            setpoint_rx       <= fr_sp;
                            duty              <= fr_duty;
                            displacement      <= fr_disp;
                            current           <= fr_cur;
                        end else begin
                            // Another slave answered; keep listening on the
                            // same timeout budget.
                            state_q <= StWaitMagic;
                            magic_q <= '0;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coms_master.sv
// ---------------------------------------------------------------------------
// tb_coms_master
//
// Directed and randomized bench for coms_master. It plays the part of the
// uart_tx (answers tx_start with tx_done after a random delay) and the
// uart_rx (streams reply frames). Expected frames and CRCs come from a
// polynomial-division model; expected status outputs come from the field
// values the bench chose when building each reply.
// ---------------------------------------------------------------------------
module tb_coms_master;

    typedef logic [7:0] bq_t[$];

    logic               CLK;
    logic               reset_n;
    logic               cmd_poll;
    logic               cmd_setpoint;
    logic [7:0]         target_id;
    logic signed [23:0] setpoint_cmd;
    logic               busy;
    logic [7:0]         tx_byte;
    logic               tx_start;
    logic               tx_done;
    logic               driver_enable;
    logic [7:0]         rx_byte;
    logic               rx_valid;
    logic [7:0]         status_id;
    logic [7:0]         control_mode;
    logic signed [23:0] encoder0_position;
    logic signed [23:0] encoder1_position;
    logic signed [23:0] setpoint_rx;
    logic signed [23:0] duty;
    logic signed [23:0] displacement;
    logic signed [12:0] current;
    logic               status_valid;
    logic               setpoint_sent;
    logic               crc_error;
    logic               timeout;

    coms_master #(
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .CLK               (CLK),
        .reset_n           (reset_n),
        .cmd_poll          (cmd_poll),
        .cmd_setpoint      (cmd_setpoint),
        .target_id         (target_id),
        .setpoint_cmd      (setpoint_cmd),
        .busy              (busy),
        .tx_byte           (tx_byte),
        .tx_start          (tx_start),
        .tx_done           (tx_done),
        .driver_enable     (driver_enable),
        .rx_byte           (rx_byte),
        .rx_valid          (rx_valid),
        .status_id         (status_id),
        .control_mode      (control_mode),
        .encoder0_position (encoder0_position),
        .encoder1_position (encoder1_position),
        .setpoint_rx       (setpoint_rx),
        .duty              (duty),
        .displacement      (displacement),
        .current           (current),
        .status_valid      (status_valid),
        .setpoint_sent     (setpoint_sent),
        .crc_error         (crc_error),
        .timeout           (timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    // Fields of the next reply frame.
    logic [7:0]         f_mode;
    logic signed [23:0] f_e0, f_e1, f_sp, f_duty, f_disp;
    logic signed [12:0] f_cur;
    logic [2:0]         f_junk;

    // Expected status outputs.
    logic [7:0]         e_id, e_mode;
    logic signed [23:0] e_e0, e_e1, e_sp, e_duty, e_disp;
    logic signed [12:0] e_cur;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of (0xFFFF * x^n + M * x^16) mod (x^16+x^15+x^2+1).
    function automatic logic [15:0] crc_ref(input bq_t msg);
        bit          bits[$];
        logic [16:0] poly;
        logic [15:0] r;
        int          len;
        poly = 17'h18005;
        foreach (msg[i]) for (int b = 7; b >= 0; b--) bits.push_back(msg[i][b]);
        for (int k = 0; k < 16; k++) bits.push_back(1'b0);
        for (int k = 0; k < 16; k++) bits[k] = ~bits[k];
        len = bits.size();
        for (int i = 0; i <= len - 17; i++)
            if (bits[i]) for (int j = 0; j < 17; j++) bits[i + j] = bits[i + j] ^ poly[16 - j];
        r = '0;
        for (int k = 0; k < 16; k++) r = {r[14:0], bits[len - 16 + k]};
        return r;
    endfunction

    function automatic bq_t req_frame(input logic [7:0] id);
        bq_t body, f;
        logic [15:0] c;
        body.push_back(id);
        c = crc_ref(body);
        f.push_back(8'h1C); f.push_back(8'hE1); f.push_back(8'hCE); f.push_back(8'hBB);
        f.push_back(id); f.push_back(c[15:8]); f.push_back(c[7:0]);
        return f;
    endfunction

    function automatic bq_t sp_frame(input logic [7:0] id, input logic [23:0] sp);
        bq_t body, f;
        logic [15:0] c;
        body.push_back(id); body.push_back(sp[23:16]);
        body.push_back(sp[15:8]); body.push_back(sp[7:0]);
        c = crc_ref(body);
        for (int k = 0; k < 4; k++) f.push_back(8'hD0);
        foreach (body[i]) f.push_back(body[i]);
        f.push_back(c[15:8]); f.push_back(c[7:0]);
        return f;
    endfunction

    function automatic void push24(inout bq_t q, input logic [23:0] v);
        q.push_back(v[23:16]); q.push_back(v[15:8]); q.push_back(v[7:0]);
    endfunction

    function automatic bq_t status_frame(input logic [7:0] fid, input bit corrupt);
        bq_t body, f;
        logic [15:0] c;
        body.push_back(fid);
        body.push_back(f_mode);
        push24(body, f_e0); push24(body, f_e1); push24(body, f_sp);
        push24(body, f_duty); push24(body, f_disp);
        body.push_back({f_junk, f_cur[12:8]});
        body.push_back(f_cur[7:0]);
        c = crc_ref(body);
        f.push_back(8'h1C); f.push_back(8'hEB); f.push_back(8'h00); f.push_back(8'hDA);
        foreach (body[i]) f.push_back(body[i]);
        f.push_back(c[15:8]);
        f.push_back(corrupt ? (c[7:0] ^ 8'hFF) : c[7:0]);
        return f;
    endfunction

    task automatic randomize_fields();
        f_mode = 8'($urandom);
        f_e0   = 24'($urandom);
        f_e1   = 24'($urandom);
        f_sp   = 24'($urandom);
        f_duty = 24'($urandom);
        f_disp = 24'($urandom);
        f_cur  = 13'($urandom);
        f_junk = 3'($urandom);
    endtask

    task automatic accept_good(input logic [7:0] id);
        e_id = id; e_mode = f_mode; e_e0 = f_e0; e_e1 = f_e1;
        e_sp = f_sp; e_duty = f_duty; e_disp = f_disp; e_cur = f_cur;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_id"},   status_id, e_id);
        check({tag, "_mode"}, control_mode, e_mode);
        check({tag, "_enc0"}, encoder0_position, e_e0);
        check({tag, "_enc1"}, encoder1_position, e_e1);
        check({tag, "_sp"},   setpoint_rx, e_sp);
        check({tag, "_duty"}, duty, e_duty);
        check({tag, "_disp"}, displacement, e_disp);
        check({tag, "_cur"},  current, e_cur);
    endtask

    task automatic check_all_zero(input string tag);
        e_id = '0; e_mode = '0; e_e0 = '0; e_e1 = '0;
        e_sp = '0; e_duty = '0; e_disp = '0; e_cur = '0;
        check({tag, "_busy"}, busy, 0);
        check({tag, "_txb"},  tx_byte, 0);
        check({tag, "_txs"},  tx_start, 0);
        check({tag, "_de"},   driver_enable, 0);
        check({tag, "_sv"},   status_valid, 0);
        check({tag, "_ss"},   setpoint_sent, 0);
        check({tag, "_ce"},   crc_error, 0);
        check({tag, "_to"},   timeout, 0);
        check_status(tag);
    endtask

    // Act as uart_tx for the given expected frame; called just after the
    // edge at which the first tx_start of the frame is due.
    task automatic collect_tx(input bq_t exp, input string tag);
        logic [7:0] b;
        int gap;
        foreach (exp[k]) begin
            check({tag, "_start"}, tx_start, 1);
            check({tag, "_byte"},  tx_byte, exp[k]);
            check({tag, "_de"},    driver_enable, 1);
            b   = tx_byte;
            gap = $urandom_range(1, 4);
            for (int g = 0; g < gap; g++) begin
                // Echo of our own byte on the bus must be discarded.
                if (g == 0) begin rx_valid = 1'b1; rx_byte = b; end
                cyc();
                rx_valid = 1'b0;
                check({tag, "_pulse"}, tx_start, 0);
                check({tag, "_hold"},  tx_byte, b);
            end
            tx_done = 1'b1;
            cyc();
            tx_done = 1'b0;
        end
    endtask

    task automatic send_rx(input bq_t q);
        int gap;
        foreach (q[i]) begin
            gap = $urandom_range(0, 2);
            repeat (gap) cyc();
            rx_byte  = q[i];
            rx_valid = 1'b1;
            cyc();
            rx_valid = 1'b0;
            rx_byte  = 8'($urandom);
        end
    endtask

    task automatic do_poll(input logic [7:0] id);
        target_id    = id;
        setpoint_cmd = 24'($urandom);
        cmd_poll     = 1'b1;
        cyc();
        cmd_poll  = 1'b0;
        target_id = 8'($urandom);
        collect_tx(req_frame(id), "req");
    endtask

    task automatic do_setpoint(input logic [7:0] id, input logic [23:0] sp, input string tag);
        target_id    = id;
        setpoint_cmd = sp;
        cmd_setpoint = 1'b1;
        cyc();
        cmd_setpoint = 1'b0;
        target_id    = 8'($urandom);
        setpoint_cmd = 24'($urandom);
        collect_tx(sp_frame(id, sp), tag);
        check({tag, "_sent"}, setpoint_sent, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_de_off"}, driver_enable, 0);
        cyc();
        check({tag, "_sent_w"}, setpoint_sent, 0);
    endtask

    task automatic poll_good(input logic [7:0] id, input string tag);
        bq_t junk;
        do_poll(id);
        junk.push_back(8'($urandom));
        junk.push_back(8'($urandom));
        send_rx(junk);
        send_rx(status_frame(id, 1'b0));
        cyc();
        check({tag, "_valid"}, status_valid, 1);
        check({tag, "_busy"},  busy, 0);
        accept_good(id);
        check_status(tag);
        cyc();
        check({tag, "_valid_w"}, status_valid, 0);
    endtask

    initial begin
        bq_t         q, part;
        int          tpos;
        bit          found, saw_tx;
        logic [7:0]  rid;
        logic [23:0] rsp;

        reset_n = 1'b0; cmd_poll = 1'b0; cmd_setpoint = 1'b0;
        target_id = '0; setpoint_cmd = '0; tx_done = 1'b0;
        rx_byte = '0; rx_valid = 1'b0;
        repeat (3) cyc();
        check_all_zero("reset");
        reset_n = 1'b1;
        cyc();

        // Setpoint write with fixed values, then a few random ones.
        do_setpoint(8'h05, 24'h123456, "sp05");
        repeat (3) do_setpoint(8'($urandom), 24'($urandom), "sp_rnd");

        // Poll with a negative encoder and negative current.
        randomize_fields();
        f_e0 = 24'hFFFFFE;
        f_cur = 13'h1F00;
        poll_good(8'h05, "poll05");
        check("enc0_neg2", encoder0_position, -32'sd2);
        check("cur_neg256", current, -32'sd256);

        repeat (3) begin
            randomize_fields();
            poll_good(8'($urandom), "poll_rnd");
        end

        // Corrupted CRC leaves the status outputs alone.
        do_poll(8'h05);
        randomize_fields();
        send_rx(status_frame(8'h05, 1'b1));
        cyc();
        check("crcerr_pulse", crc_error, 1);
        check("crcerr_valid", status_valid, 0);
        check("crcerr_busy", busy, 0);
        check_status("crcerr");
        cyc();
        check("crcerr_w", crc_error, 0);

        // No reply; a command while waiting must be ignored.
        do_poll(8'h05);
        found = 1'b0; saw_tx = 1'b0; tpos = 0;
        for (int n = 1; n <= 1100; n++) begin
            if (n == 10) begin cmd_setpoint = 1'b1; target_id = 8'h33; end
            cyc();
            cmd_setpoint = 1'b0;
            if (tx_start === 1'b1) saw_tx = 1'b1;
            if (timeout === 1'b1) begin found = 1'b1; tpos = n; break; end
        end
        check("to_latency", tpos, 1000);
        check("to_busy", busy, 0);
        check("to_no_tx", saw_tx, 0);
        cyc();
        check("to_pulse_w", timeout, 0);
        check_status("to");

        // Reply from the wrong slave, then from the right one.
        do_poll(8'h05);
        randomize_fields();
        send_rx(status_frame(8'h07, 1'b0));
        cyc();
        check("idmis_valid", status_valid, 0);
        check("idmis_busy", busy, 1);
        check("idmis_crcerr", crc_error, 0);
        check_status("idmis");
        randomize_fields();
        send_rx(status_frame(8'h05, 1'b0));
        cyc();
        check("idok_valid", status_valid, 1);
        accept_good(8'h05);
        check_status("idok");
        check("idok_id05", status_id, 8'h05);

        // Reset in the middle of a status request.
        target_id = 8'h05;
        cmd_poll  = 1'b1;
        cyc();
        cmd_poll = 1'b0;
        q = req_frame(8'h05);
        part.push_back(q[0]);
        part.push_back(q[1]);
        collect_tx(part, "req_part");
        check("rst_third_start", tx_start, 1);
        reset_n = 1'b0;
        repeat (3) begin
            cyc();
            check_all_zero("mid_reset");
        end
        reset_n = 1'b1;
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        saw_tx  = (tx_start === 1'b1) || (busy !== 1'b0);
        repeat (4) begin
            cyc();
            if (tx_start === 1'b1 || busy !== 1'b0) saw_tx = 1'b1;
        end
        check("rst_abort", saw_tx, 0);

        rid = 8'($urandom);
        rsp = 24'($urandom);
        target_id    = rid;
        setpoint_cmd = rsp;
        cmd_poll     = 1'b1;
        cmd_setpoint = 1'b1;
        cyc();
        cmd_poll = 1'b0;
        cmd_setpoint = 1'b0;
        collect_tx(sp_frame(rid, rsp), "both");
        check("both_sent", setpoint_sent, 1);
        saw_tx = 1'b0;
        repeat (30) begin
            cyc();
            if (tx_start === 1'b1 || busy !== 1'b0) saw_tx = 1'b1;
        end
        check("both_no_poll", saw_tx, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d",
                 n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/coms_master.md
COMS_MASTER -- requirements
Module: coms_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 500000, meaning the response-wait limit in CLK cycles.
REQ-002 The block SHALL have these ports:
  - CLK  in  1  system clock; one clock, all logic on its rising edge.
  - reset_n  in  1  reset, synchronous and active-low.
  - cmd_poll  in  1  single-cycle pulse requesting a status poll of target_id.
  - cmd_setpoint  in  1  single-cycle pulse requesting a setpoint write to target_id.
  - target_id  in  8  slave ID, sampled on command acceptance.
  - setpoint_cmd  in  24 signed  setpoint value, sampled on command acceptance.
  - busy  out  1  high whenever state is not IDLE.
  - tx_byte  out  8  byte handed to the external uart_tx.
  - tx_start  out  1  single-cycle pulse: uart_tx transmits tx_byte.
  - tx_done  in  1  single-cycle pulse from uart_tx: byte finished.
  - driver_enable  out  1  RS485 driver enable.
  - rx_byte  in  8  byte from the external uart_rx.
  - rx_valid  in  1  single-cycle pulse: rx_byte is valid.
  - status_id  out  8  ID field of the last good status frame.
  - control_mode  out  8  control mode field of the last good status frame.
  - encoder0_position, encoder1_position, setpoint_rx, duty, displacement  out  24 signed each  matching fields of the last good status frame.
  - current  out  13 signed  current field of the last good status frame.
  - status_valid  out  1  pulse: a good status frame was captured.
  - setpoint_sent  out  1  pulse: a setpoint frame finished transmitting.
  - crc_error  out  1  pulse: a status frame failed its CRC check.
  - timeout  out  1  pulse: no good status frame arrived within TIMEOUT_CYCLES.

Function
REQ-003 The CRC SHALL be CRC-16 with polynomial x^16+x^15+x^2+1, initial value 0xFFFF, bytewise, with data bit 7 as the first serial bit, no final XOR; it is transmitted high byte first.
REQ-004 The status request frame SHALL be 7 bytes: 1C E1 CE BB, target_id, CRC_hi, CRC_lo; the CRC covers target_id only.
REQ-005 The setpoint frame SHALL be 10 bytes: D0 D0 D0 D0, target_id, sp[23:16], sp[15:8], sp[7:0], CRC_hi, CRC_lo; the CRC covers bytes 4..7.
REQ-006 The status frame SHALL be 25 bytes, laid out as follows:
  - bytes 0..3: 1C EB 00 DA.
  - byte 4: ID; byte 5: control_mode.
  - bytes 6..8: enc0; 9..11: enc1; 12..14: setpoint; 15..17: duty; 18..20: displacement; all MSB first.
  - byte 21[4:0]: current[12:8]; byte 22: current[7:0].
  - bytes 23..24: CRC, covering bytes 4..22.
REQ-007 The state machine SHALL have states IDLE, SEND_REQ, SEND_SP, WAIT_MAGIC, RECV_STATUS, CHECK_CRC.
REQ-008 Commands SHALL be accepted only in IDLE; commands arriving while busy are ignored.
REQ-009 When cmd_poll and cmd_setpoint arrive together, cmd_setpoint SHALL win and the poll is dropped.
REQ-010 In a SEND state, tx_start SHALL pulse once per byte, and tx_byte SHALL be held from that pulse until tx_done.
REQ-011 The next tx_start SHALL be issued exactly 1 cycle after the tx_done of the previous byte.
REQ-012 The first tx_start SHALL occur 1 cycle after command acceptance.
REQ-013 driver_enable SHALL be 1 in SEND_REQ and SEND_SP and 0 otherwise.
REQ-014 After the last tx_done of SEND_SP, the block SHALL pulse setpoint_sent and go to IDLE in the same cycle.
REQ-015 After the last tx_done of SEND_REQ, the block SHALL go to WAIT_MAGIC, clear the 4-byte magic shift register, and zero the timeout counter.
REQ-016 rx_valid SHALL be ignored outside WAIT_MAGIC and RECV_STATUS, so RS485 echo of the block's own bytes is discarded.
REQ-017 In WAIT_MAGIC, each rx_valid SHALL shift rx_byte into the magic register; when it equals 0x1CEB00DA the block goes to RECV_STATUS with the byte index at 0.
REQ-018 In RECV_STATUS, the block SHALL store 21 bytes (frame bytes 4..24), then go to CHECK_CRC.
REQ-019 CHECK_CRC SHALL take 1 cycle, with three outcomes:
  - CRC matches and ID equals the latched target_id: update all status outputs, pulse status_valid, go to IDLE.
  - CRC mismatch: pulse crc_error, go to IDLE.
  - CRC good but ID mismatch: return to WAIT_MAGIC with the magic register cleared and the timeout counter not reset.
REQ-020 The timeout counter SHALL increment every cycle in WAIT_MAGIC, RECV_STATUS and CHECK_CRC.
REQ-021 When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse timeout and go to IDLE; this takes precedence over a simultaneous rx_valid.
REQ-022 current SHALL be taken from byte 21[4:0] and byte 22; bits 7:5 of byte 21 are ignored.
REQ-023 Status outputs SHALL change only on a good frame; a bad or missing frame leaves them unchanged.
REQ-024 All pulse outputs SHALL be exactly 1 cycle wide.

Reset
REQ-025 When reset_n is 0 at a rising edge, the block SHALL enter IDLE and zero all counters, registers and outputs, including driver_enable, tx_start and every pulse.
REQ-026 A reset during any transmission or reception SHALL abort it at once, with no further tx_start issued.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
  - cmd_setpoint with id 0x05, sp 0x123456 -> tx bytes D0 D0 D0 D0 05 12 34 56 plus reference-model CRC; setpoint_sent pulses after the 10th tx_done; driver_enable is high throughout the frame.
  - cmd_poll with id 0x05; bench replies with a valid frame carrying enc0 0xFFFFFE and current 0x1F00 -> request bytes 1C E1 CE BB 05 plus CRC; then status_valid pulses, encoder0_position = -2, current = -256.
  - Poll, then a reply with the last CRC byte flipped -> crc_error pulses, status outputs unchanged, busy drops.
  - Poll with TIMEOUT_CYCLES=1000 and no reply -> timeout pulses exactly 1000 cycles after WAIT_MAGIC entry.
  - Poll id 0x05; a good frame with ID 0x07 arrives, then a good frame with ID 0x05 -> only the second sets status_valid, and status_id = 0x05.
  - reset_n low mid-SEND_REQ, then cmd_poll and cmd_setpoint together -> all outputs zero during reset; afterwards a setpoint frame is sent and no poll.
